// File: rtl/MSX.sv
// Shared MSX core types used by the SDRAM byte-port arbiter and the slot logic.
//   lookup_RAM_t : one RAM block descriptor (SDRAM base, size in 16 KB pages, read-only)
//   arb_state_t  : arbiter FSM states
//   ram_req_t    : one captured byte request
//   REQ_*        : requester indices into req/ack/err
package MSX;

  typedef struct packed {
    logic [26:0] addr;
    logic [7:0]  size;
    logic        ro;
  } lookup_RAM_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CHECK,
    ARB_ISSUE,
    ARB_DONE
  } arb_state_t;

  localparam int unsigned REQ_LOADER = 0;
  localparam int unsigned REQ_CPU    = 1;
  localparam int unsigned REQ_DEV    = 2;

  typedef struct packed {
    logic        we;
    logic [3:0]  ref_ram;
    logic [26:0] offset;
    logic [7:0]  wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_lookup_check.sv
// Translates a block-relative byte offset to an SDRAM address and flags access faults.
//   entry  : block descriptor selected by the request's ref_ram
//   offset : byte offset inside the block
//   we     : request is a write
//   addr   : entry.addr + offset, wrapped to 27 bits
//   fault  : offset past the block end (size in 16 KB pages) or a write to a read-only block
module ram_lookup_check
  import MSX::*;
(
  input  lookup_RAM_t entry,
  input  logic [26:0] offset,
  input  logic        we,
  output logic [26:0] addr,
  output logic        fault
);

  assign addr  = entry.addr + offset;
  // size == 0 makes every page index out of range
  assign fault = (offset[26:14] >= {5'd0, entry.size}) || (we && entry.ro);

endmodule

// File: rtl/msx_ram_arbiter.sv
// Arbitrates the single SDRAM byte port between the loader, CPU and device paths.
//   clk, reset_n         : core clock, synchronous active-low reset
//   lookup_RAM           : block table indexed by ref_ram
//   req/we/ref_ram/offset/wdata : per-requester request and operands (0 loader, 1 CPU, 2 device)
//   ack/err/rdata        : one-cycle completion pulse, error flag, last read byte
//   mem_*                : SDRAM request/response port
module msx_ram_arbiter
  import MSX::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  lookup_RAM_t      lookup_RAM [16],
  input  logic [2:0]       req,
  input  logic [2:0]       we,
  input  logic [2:0][3:0]  ref_ram,
  input  logic [2:0][26:0] offset,
  input  logic [2:0][7:0]  wdata,
  output logic [2:0]       ack,
  output logic [2:0]       err,
  output logic [7:0]       rdata,
  output logic [26:0]      mem_addr,
  output logic [7:0]       mem_din,
  output logic             mem_we,
  output logic             mem_req,
  input  logic             mem_ack,
  input  logic [7:0]       mem_dout
);

  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  arb_state_t      state_d, state_q;
  ram_req_t        cap_d, cap_q;
  logic [1:0]      win_d, win_q;
  logic            err_d, err_q;
  logic            rr_d, rr_q;      // 0: CPU wins a CPU/device tie, 1: device wins
  logic [CntW-1:0] cnt_d, cnt_q;
  logic [7:0]      rdata_d, rdata_q;
  logic [26:0]     addr_d, addr_q;
  logic [7:0]      din_d, din_q;
  logic            we_d, we_q;
  logic [1:0]      pick;
  logic [26:0]     chk_addr;
  logic            chk_fault;

  ram_lookup_check u_check (
    .entry  (lookup_RAM[cap_q.ref_ram]),
    .offset (cap_q.offset),
    .we     (cap_q.we),
    .addr   (chk_addr),
    .fault  (chk_fault)
  );

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    win_d   = win_q;
    err_d   = err_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = we_q;
    ack     = '0;
    err     = '0;

    // Loader first, then CPU/device by the round-robin pointer
    if (req[REQ_LOADER]) begin
      pick = 2'(REQ_LOADER);
    end else if (req[REQ_CPU] && (!req[REQ_DEV] || !rr_q)) begin
      pick = 2'(REQ_CPU);
    end else begin
      pick = 2'(REQ_DEV);
    end

    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          win_d         = pick;
          cap_d.we      = we[pick];
          cap_d.ref_ram = ref_ram[pick];
          cap_d.offset  = offset[pick];
          cap_d.wdata   = wdata[pick];
          err_d         = 1'b0;
          if (pick != 2'(REQ_LOADER)) begin
            rr_d = ~rr_q;
          end
          state_d = ARB_CHECK;
        end
      end
      ARB_CHECK: begin
        if (chk_fault) begin
          err_d   = 1'b1;
          state_d = ARB_DONE;
        end else begin
          addr_d  = chk_addr;
          din_d   = cap_q.wdata;
          we_d    = cap_q.we;
          cnt_d   = '0;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_ack) begin
          if (!cap_q.we) begin
            rdata_d = mem_dout;
          end
          state_d = ARB_DONE;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ARB_DONE: begin
        ack[win_q] = 1'b1;
        err[win_q] = err_q;
        state_d    = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      cap_q   <= '0;
      win_q   <= '0;
      err_q   <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      win_q   <= win_d;
      err_q   <= err_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
    end
  end

  assign mem_req  = (state_q == ARB_ISSUE);
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_we   = we_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_msx_ram_arbiter.sv
module tb_msx_ram_arbiter;

  localparam int unsigned TO = 8;

  logic             clk;
  logic             reset_n;
  MSX::lookup_RAM_t lut [16];
  logic [2:0]       req, we;
  logic [2:0][3:0]  ref_ram;
  logic [2:0][26:0] offset;
  logic [2:0][7:0]  wdata;
  logic [2:0]       ack, err;
  logic [7:0]       rdata;
  logic [26:0]      mem_addr;
  logic [7:0]       mem_din;
  logic             mem_we, mem_req, mem_ack;
  logic [7:0]       mem_dout;

  int n_tests = 0;
  int n_fail  = 0;

  msx_ram_arbiter #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .lookup_RAM (lut),
    .req        (req),
    .we         (we),
    .ref_ram    (ref_ram),
    .offset     (offset),
    .wdata      (wdata),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- Transaction-level reference model ----------------
  // Timing follows the request rules: grant at cycle g, reject ack at g+2, SDRAM request
  // from g+2 until mem_ack (ack one cycle later) or until g+2+TO (timeout ack one later).
  longint      cyc = 0, t_grant = 0, t_ack = -1;
  bit          armed = 0, busy = 0, flt = 0, ewe = 0, fav_dev = 0, e_errbit = 0;
  bit          issue_done = 0, in_issue = 0, l_we = 0;
  int          win = 0;
  logic [26:0] eaddr = '0, l_addr = '0;
  logic [7:0]  ewd = '0, l_din = '0, e_rdata = '0;
  logic [2:0]  e_ack, e_err;

  initial begin : model
    MSX::lookup_RAM_t ent;
    forever begin
      @(negedge clk);
      in_issue = busy && !flt && !issue_done && (cyc >= t_grant + 2);
      if (armed) begin
        e_ack = '0;
        e_err = '0;
        if (busy && cyc == t_ack) begin
          e_ack[win] = 1'b1;
          e_err[win] = e_errbit;
        end
        if (busy && !flt && cyc == t_grant + 2) begin
          l_addr = eaddr;
          l_din  = ewd;
          l_we   = ewe;
        end
        chk("ack", 32'(ack), 32'(e_ack));
        chk("err", 32'(err), 32'(e_err));
        chk("mem_req", 32'(mem_req), 32'(in_issue));
        chk("mem_addr", 32'(mem_addr), 32'(l_addr));
        chk("mem_din", 32'(mem_din), 32'(l_din));
        chk("mem_we", 32'(mem_we), 32'(l_we));
        chk("rdata", 32'(rdata), 32'(e_rdata));
      end
      if (!reset_n) begin
        busy    = 0;
        fav_dev = 0;
        l_addr  = '0;
        l_din   = '0;
        l_we    = 0;
        e_rdata = '0;
        armed   = 1;
      end else if (armed) begin
        if (busy) begin
          if (in_issue) begin
            if (mem_ack === 1'b1) begin
              issue_done = 1;
              t_ack      = cyc + 1;
              e_errbit   = 0;
              if (!ewe) e_rdata = mem_dout;
            end else if (cyc == t_grant + 2 + TO) begin
              issue_done = 1;
              t_ack      = cyc + 1;
              e_errbit   = 1;
            end
          end
          if (cyc == t_ack) busy = 0;
        end else if (req != 3'b000) begin
          if (req[0]) win = 0;
          else if (req[1] && req[2]) win = fav_dev ? 2 : 1;
          else if (req[1]) win = 1;
          else win = 2;
          if (win != 0) fav_dev = !fav_dev;
          ent        = lut[ref_ram[win]];
          ewe        = we[win];
          ewd        = wdata[win];
          eaddr      = 27'(ent.addr + offset[win]);
          flt        = ((int'(offset[win]) / 16384) >= int'(ent.size)) || (we[win] && ent.ro);
          e_errbit   = flt;
          t_grant    = cyc;
          t_ack      = flt ? cyc + 2 : -1;
          issue_done = 0;
          busy       = 1;
        end
      end
      cyc++;
    end
  end

  // ---------------- Stimulus ----------------
  task automatic set_req(input int i, input logic w, input logic [3:0] r,
                         input logic [26:0] o, input logic [7:0] d);
    req[i]     = 1'b1;
    we[i]      = w;
    ref_ram[i] = r;
    offset[i]  = o;
    wdata[i]   = d;
  endtask

  initial begin : stim
    logic [2:0] seq [5];
    logic [2:0] exp_seq [5];
    logic [2:0] seen;
    bit         pend [3];
    int         n, p;

    reset_n = 1'b0;
    req = '0; we = '0; ref_ram = '0; offset = '0; wdata = '0;
    mem_ack = 1'b0; mem_dout = 8'h00;
    for (int i = 0; i < 16; i++) begin
      lut[i].addr = 27'($urandom);
      lut[i].size = 8'($urandom_range(0, 3));
      lut[i].ro   = 1'($urandom_range(0, 1));
    end
    lut[0] = '{addr: 27'h0000000, size: 8'd0, ro: 1'b0};
    lut[1] = '{addr: 27'h0200000, size: 8'd1, ro: 1'b0};
    lut[2] = '{addr: 27'h0100000, size: 8'd2, ro: 1'b0};
    lut[3] = '{addr: 27'h0300000, size: 8'd4, ro: 1'b1};
    lut[4] = '{addr: 27'h7FFFF00, size: 8'd1, ro: 1'b0};

    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    tick();

    // Loader write, SDRAM acks on the third cycle of mem_req
    set_req(0, 1'b1, 4'd2, 27'h0000123, 8'h5A);
    tick(); tick();
    @(negedge clk);
    chk("d1_mem_req", 32'(mem_req), 32'h1);
    chk("d1_mem_addr", 32'(mem_addr), 32'h0100123);
    chk("d1_mem_we", 32'(mem_we), 32'h1);
    chk("d1_mem_din", 32'(mem_din), 32'h5A);
    tick();
    tick(); mem_ack = 1'b1;
    tick(); mem_ack = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    chk("d1_ack", 32'(ack), 32'h1);
    chk("d1_err", 32'(err), 32'h0);
    repeat (3) tick();

    // CPU read one page past a 1-page block
    set_req(1, 1'b0, 4'd1, 27'h0004000, 8'h00);
    tick();
    @(negedge clk);
    chk("d2_mem_req_c1", 32'(mem_req), 32'h0);
    tick(); req[1] = 1'b0;
    @(negedge clk);
    chk("d2_ack", 32'(ack), 32'h2);
    chk("d2_err", 32'(err), 32'h2);
    chk("d2_mem_req_c2", 32'(mem_req), 32'h0);
    repeat (3) tick();

    // Device write to read-only block, then a read of it
    set_req(2, 1'b1, 4'd3, 27'h0000040, 8'h77);
    tick(); tick(); req[2] = 1'b0;
    @(negedge clk);
    chk("d3w_ack", 32'(ack), 32'h4);
    chk("d3w_err", 32'(err), 32'h4);
    chk("d3w_mem_req", 32'(mem_req), 32'h0);
    repeat (3) tick();
    set_req(2, 1'b0, 4'd3, 27'h0000040, 8'h00);
    tick();
    tick(); mem_ack = 1'b1; mem_dout = 8'hA5;
    tick(); mem_ack = 1'b0; mem_dout = 8'h00; req[2] = 1'b0;
    @(negedge clk);
    chk("d3r_ack", 32'(ack), 32'h4);
    chk("d3r_err", 32'(err), 32'h0);
    chk("d3r_rdata", 32'(rdata), 32'hA5);
    repeat (3) tick();

    // Timeout with mem_ack withheld, then a late mem_ack
    set_req(1, 1'b0, 4'd2, 27'h0000010, 8'h00);
    repeat (10) tick();
    @(negedge clk);
    chk("d5_mem_req_last", 32'(mem_req), 32'h1);
    tick(); req[1] = 1'b0;
    @(negedge clk);
    chk("d5_mem_req_drop", 32'(mem_req), 32'h0);
    chk("d5_ack", 32'(ack), 32'h2);
    chk("d5_err", 32'(err), 32'h2);
    chk("d5_rdata_kept", 32'(rdata), 32'hA5);
    tick(); mem_ack = 1'b1;
    @(negedge clk);
    chk("d5_late_ack", 32'(ack), 32'h0);
    tick(); mem_ack = 1'b0;
    @(negedge clk);
    chk("d5_late_ack2", 32'(ack), 32'h0);
    repeat (3) tick();

    // Reset while in ISSUE
    set_req(1, 1'b0, 4'd1, 27'h0000010, 8'h00);
    tick(); tick(); tick(); reset_n = 1'b0; req[1] = 1'b0;
    @(negedge clk);
    chk("d6_mem_req_pre", 32'(mem_req), 32'h1);
    tick(); reset_n = 1'b1;
    @(negedge clk);
    chk("d6_mem_req", 32'(mem_req), 32'h0);
    chk("d6_mem_addr", 32'(mem_addr), 32'h0);
    chk("d6_rdata", 32'(rdata), 32'h0);
    chk("d6_ack", 32'(ack), 32'h0);
    tick();

    // CPU and device held continuously; loader joins after the second grant
    mem_ack = 1'b1; mem_dout = 8'h3C;
    set_req(1, 1'b0, 4'd1, 27'h0000010, 8'h00);
    set_req(2, 1'b0, 4'd3, 27'h0000020, 8'h00);
    for (int k = 0; k < 5; k++) seq[k] = 3'b000;
    exp_seq[0] = 3'b010; exp_seq[1] = 3'b100; exp_seq[2] = 3'b001;
    exp_seq[3] = 3'b010; exp_seq[4] = 3'b100;
    n = 0;
    for (int k = 0; k < 60 && n < 5; k++) begin
      @(negedge clk);
      seen = ack;
      if (seen != 3'b000) begin
        seq[n] = seen;
        n++;
      end
      tick();
      if (seen != 3'b000 && n == 2) set_req(0, 1'b1, 4'd2, 27'h0000200, 8'hC3);
      if (seen[0]) req[0] = 1'b0;
    end
    for (int k = 0; k < 5; k++) chk($sformatf("d4_grant%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
    req = '0; mem_ack = 1'b0;
    repeat (8) tick();

    // Randomized traffic: three mem_ack densities (normal, withheld, always)
    for (int i = 0; i < 3; i++) pend[i] = 0;
    for (int k = 0; k < 3600; k++) begin
      @(negedge clk);
      seen = ack;
      tick();
      p = (k < 2400) ? 4 : ((k < 3000) ? 0 : 10);
      for (int i = 0; i < 3; i++) begin
        if (pend[i] && seen[i]) begin
          pend[i] = 0;
          req[i]  = 1'b0;
        end
        if (!pend[i] && $urandom_range(0, (i == 0) ? 15 : 3) == 0) begin
          pend[i] = 1;
          set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? 27'($urandom)
                                              : 27'($urandom_range(0, 5 * 16384 - 1)),
                  8'($urandom));
        end
      end
      mem_ack  = ($urandom_range(0, 9) < p) ? 1'b1 : 1'b0;
      mem_dout = 8'($urandom);
    end
    req = '0; mem_ack = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
